fifo_queue_ctrl: RTL and testbench

Circular-queue controller that drives the write port and two read ports of the team's multi-port register file, turning it into an 8-entry × 4-bit FIFO for the lab board. It converts push/pop button levels into single-cycle operations and maintains head/tail pointers, occupancy and full/empty flags. It also runs a scan counter over the third read port so the display can show every slot with its occupied flag. Sits between the board I/O (switches, debounced buttons, display driver) and the register file instance.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/edge_pulse.sv | 21 ++
 rtl/fifo_queue_ctrl.sv | 122 ++++++++++++
 tb/tb_fifo_queue_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing and operation encoding for the lab-board FIFO controller.
package fifo_pkg;

    localparam int DATA_W   = 4;
    localparam int ADDR_W   = 3;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int SCAN_DIV = 16;

    // Encoding matches {do_push, do_pop} so the top can cast directly.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } q_op_e;

endpackage

// File: rtl/edge_pulse.sv
// Turns a level into a one-cycle pulse on its rising edge.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/fifo_queue_ctrl.sv
// Circular-queue controller over a multi-port register file, with a slow
// scan of every slot for the display.
module fifo_queue_ctrl #(
    parameter int DATA_W   = fifo_pkg::DATA_W,
    parameter int ADDR_W   = fifo_pkg::ADDR_W,
    parameter int SCAN_DIV = fifo_pkg::SCAN_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_in,
    input  logic              pop_in,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic [ADDR_W-1:0] rf_ra0,
    input  logic [DATA_W-1:0] rf_rd0,
    output logic [ADDR_W-1:0] rf_ra2,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_valid
);

    import fifo_pkg::*;

    localparam int DEPTH_L = 1 << ADDR_W;
    localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH_L);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0]  DIV_TC   = DIV_W'(SCAN_DIV - 1);

    logic              push_p;
    logic              pop_p;
    logic              do_push;
    logic              do_pop;
    q_op_e             op;
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] scan_idx;
    logic [ADDR_W-1:0] scan_rel;
    logic [DIV_W-1:0]  div_cnt;

    edge_pulse u_push_edge (
        .clk   (clk),
        .rst   (rst),
        .level (push_in),
        .pulse (push_p)
    );

    edge_pulse u_pop_edge (
        .clk   (clk),
        .rst   (rst),
        .level (pop_in),
        .pulse (pop_p)
    );

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    // A pop on a full queue frees the slot the simultaneous push lands in.
    // Both are blocked while in reset so no stray write reaches the file.
    always_comb begin
        do_pop  = pop_p & ~empty & ~rst;
        do_push = push_p & (~full | do_pop) & ~rst;
        op      = q_op_e'({do_push, do_pop});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            dout  <= '0;
        end else begin
            case (op)
                OP_PUSH: count <= count + CNT_ONE;
                OP_POP:  count <= count - CNT_ONE;
                default: ;
            endcase
            if (do_push) begin
                tail <= tail + PTR_ONE;
            end
            if (do_pop) begin
                head <= head + PTR_ONE;
                dout <= rf_rd0;
            end
        end
    end

    assign rf_we  = do_push;
    assign rf_wa  = tail;
    assign rf_wd  = din;
    assign rf_ra0 = head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            scan_idx <= '0;
        end else if (div_cnt == DIV_TC) begin
            div_cnt  <= '0;
            scan_idx <= scan_idx + PTR_ONE;
        end else begin
            div_cnt  <= div_cnt + DIV_ONE;
        end
    end

    // Slot is occupied when its distance past head is below the occupancy.
    assign scan_rel   = scan_idx - head;
    assign scan_valid = ({1'b0, scan_rel} < count);
    assign rf_ra2     = scan_idx;
    assign scan_addr  = scan_idx;
    assign scan_data  = rf_rd2;

endmodule

// File: tb/tb_fifo_queue_ctrl.sv
// Bench for fifo_queue_ctrl: queue-based reference model, per-cycle compare,
// directed literal checks and randomized button activity.
module tb_fifo_queue_ctrl;

    import fifo_pkg::*;

    localparam int SD = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              push_in = 1'b0;
    logic              pop_in = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic [ADDR_W-1:0] rf_ra0;
    logic [DATA_W-1:0] rf_rd0;
    logic [ADDR_W-1:0] rf_ra2;
    logic [DATA_W-1:0] rf_rd2;
    logic [ADDR_W-1:0] scan_addr;
    logic [DATA_W-1:0] scan_data;
    logic              scan_valid;

    always #5 clk = ~clk;

    fifo_queue_ctrl #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .SCAN_DIV (SD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push_in    (push_in),
        .pop_in     (pop_in),
        .din        (din),
        .dout       (dout),
        .full       (full),
        .empty      (empty),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .rf_ra0     (rf_ra0),
        .rf_rd0     (rf_rd0),
        .rf_ra2     (rf_ra2),
        .rf_rd2     (rf_rd2),
        .scan_addr  (scan_addr),
        .scan_data  (scan_data),
        .scan_valid (scan_valid)
    );

    // Register file stand-in: clocked write, combinational reads, entry 0 reset.
    logic [DATA_W-1:0] rf_mem [DEPTH];
    always @(posedge clk or posedge rst) begin
        if (rst) rf_mem[0] <= '0;
        else if (rf_we) rf_mem[rf_wa] <= rf_wd;
    end
    assign rf_rd0 = rf_mem[rf_ra0];
    assign rf_rd2 = rf_mem[rf_ra2];

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    bit cmp_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of entries plus slot contents and counters.
    int mq[$];
    int m_slot[DEPTH];
    int m_head = 0;
    int m_tail = 0;
    int m_dout = 0;
    int m_cyc = 0;
    bit m_pprev = 0;
    bit m_oprev = 0;
    bit m_pp, m_po, m_pok, m_puk;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_head = 0; m_tail = 0; m_dout = 0; m_cyc = 0;
                m_pprev = 0; m_oprev = 0;
            end else begin
                m_pp  = push_in && !m_pprev;
                m_po  = pop_in && !m_oprev;
                m_pok = m_po && (mq.size() > 0);
                m_puk = m_pp && ((mq.size() < DEPTH) || m_pok);
                if (m_pok) begin
                    m_dout = mq.pop_front();
                    m_head = (m_head + 1) % DEPTH;
                end
                if (m_puk) begin
                    mq.push_back(int'(din));
                    m_slot[m_tail] = int'(din);
                    m_tail = (m_tail + 1) % DEPTH;
                end
                m_pprev = push_in;
                m_oprev = pop_in;
                m_cyc++;
            end
        end
    end

    int c_n, c_idx;
    bit c_pp, c_po, c_we, c_occ;

    initial begin
        forever begin
            @(negedge clk);
            if (rf_we) we_cnt++;
            if (cmp_en) begin
                c_n   = mq.size();
                c_pp  = push_in && !m_pprev;
                c_po  = pop_in && !m_oprev;
                c_we  = !rst && c_pp && ((c_n < DEPTH) || (c_po && c_n > 0));
                c_idx = (m_cyc / SD) % DEPTH;
                c_occ = ((c_idx - m_head + DEPTH) % DEPTH) < c_n;
                chk("rf_we", rf_we, c_we);
                if (c_we) chk("rf_wa", rf_wa, m_tail);
                chk("rf_wd", rf_wd, din);
                chk("rf_ra0", rf_ra0, m_head);
                chk("dout", dout, m_dout);
                chk("full", full, c_n == DEPTH);
                chk("empty", empty, c_n == 0);
                chk("scan_addr", scan_addr, c_idx);
                chk("rf_ra2", rf_ra2, c_idx);
                chk("scan_valid", scan_valid, c_occ);
                if (c_occ) chk("scan_data", scan_data, m_slot[c_idx]);
            end
        end
    end

    task automatic cyc(input bit pu, input bit po, input logic [DATA_W-1:0] d);
        push_in = pu;
        pop_in  = po;
        din     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic press_push(input logic [DATA_W-1:0] d);
        cyc(1'b1, 1'b0, d);
        cyc(1'b0, 1'b0, d);
    endtask

    task automatic press_pop();
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, '0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        push_in = 1'b0;
        pop_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int w0, hsnap, n_c;

    initial begin
        cmp_en = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_dout", dout, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_scan_addr", scan_addr, 0);
        chk("rst_scan_valid", scan_valid, 0);
        chk("rst_rf_we", rf_we, 0);

        for (int v = 1; v <= 3; v++) press_push(4'(v));
        chk("three_empty", empty, 0);
        for (int v = 1; v <= 3; v++) begin
            press_pop();
            chk("fifo_order", dout, v);
        end
        chk("drained_empty", empty, 1);

        for (int v = 0; v < 8; v++) press_push(4'(v));
        chk("eight_full", full, 1);
        push_in = 1'b1;
        din = 4'd9;
        #1;
        chk("push_full_we", rf_we, 0);
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, '0);
        chk("still_full", full, 1);
        for (int i = 0; i < 4; i++) begin
            press_pop();
            chk("wrap_pop_a", dout, i);
        end
        for (int v = 8; v < 12; v++) press_push(4'(v));
        chk("wrap_full", full, 1);
        for (int i = 0; i < 8; i++) begin
            press_pop();
            chk("wrap_pop_b", dout, i + 4);
        end
        chk("wrap_empty", empty, 1);

        w0 = we_cnt;
        push_in = 1'b1;
        din = 4'd5;
        repeat (20) @(posedge clk);
        #1;
        push_in = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_writes", we_cnt - w0, 1);
        press_pop();
        chk("hold_dout", dout, 5);
        chk("hold_empty", empty, 1);

        for (int v = 0; v < 8; v++) press_push(4'(v));
        cyc(1'b1, 1'b1, 4'hA);
        chk("both_full_dout", dout, 0);
        chk("both_full_full", full, 1);
        cyc(1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) begin
            press_pop();
            chk("both_full_drain", dout, (i < 7) ? i + 1 : 10);
        end
        chk("both_full_empty", empty, 1);

        cyc(1'b1, 1'b1, 4'd3);
        chk("both_empty_dout", dout, 10);
        chk("both_empty_nonempty", empty, 0);
        cyc(1'b0, 1'b0, '0);
        press_pop();
        chk("both_empty_pop", dout, 3);
        chk("both_empty_after", empty, 1);

        hsnap = m_head;
        press_pop();
        chk("pop_empty_dout", dout, 3);
        chk("pop_empty_head", rf_ra0, hsnap);

        for (int ph = 0; ph < 2; ph++) begin
            repeat (1500) begin
                cyc(1'($urandom_range(0, 1)),
                    (ph == 0) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)));
            end
        end

        apply_reset();
        press_push(4'd5);
        press_push(4'd6);
        for (int k = 1; k <= 8; k++) begin
            n_c = 0;
            while (scan_addr != 3'(k % 8) && n_c < 4 * SD) begin
                @(negedge clk);
                n_c++;
            end
            chk("scan_reach", scan_addr, k % 8);
            if (k >= 2) chk("scan_step", n_c, SD);
            chk("scan_valid_lit", scan_valid, (k % 8) < 2);
        end

        repeat (5) @(posedge clk);
        #1;
        push_in = 1'b1;
        din = 4'd7;
        rst = 1'b1;
        #1;
        chk("midrst_scan", scan_addr, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_dout", dout, 0);
        chk("midrst_we", rf_we, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        w0 = we_cnt;
        @(posedge clk);
        #1;
        chk("held_push_empty", empty, 0);
        push_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("held_push_one", we_cnt - w0, 1);
        press_pop();
        chk("held_push_dout", dout, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
